// File: rtl/top_pkg.sv
// top_pkg: shared definitions for the RV32I single-cycle core.
//   - opcode constants for the supported instruction formats
//   - ALUControl encodings (alu_ctrl_e) and the ALU-op / ImmSrc /
//     ResultSrc selector typedefs
//   - imm_extend(): builds the sign-extended immediate for a format
package top_pkg;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_e;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    // All immediates sign-extend from instruction bit 31; branch and jump
    // offsets are half-word granular, so their bit 0 is always zero.
    function automatic logic [31:0] imm_extend(input logic [31:7] instr,
                                               input imm_src_e     src);
        logic [31:0] imm;
        case (src)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_J:   imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/control_unit.sv
// control_unit: combinational main + ALU decoder.
//   in : op, funct3, funct7b5 (instruction fields)
//   out: reg_write, mem_write, alu_src, branch, jump, imm_src,
//        result_src, alu_control
// Optional feature: define TOP_JAL_EN to decode jal; otherwise opcode
// 1101111 falls into the no-op default like any other unknown opcode.
module control_unit
    import top_pkg::*;
(
    input  logic [6:0]  op,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    output logic        reg_write,
    output logic        mem_write,
    output logic        alu_src,
    output logic        branch,
    output logic        jump,
    output imm_src_e    imm_src,
    output result_src_e result_src,
    output alu_ctrl_e   alu_control
);

    alu_op_e alu_op;
    logic    funct_ok;

    // Only add/sub, slt, or, and are implemented; other funct3 values
    // of the ALU formats are treated as no-ops.
    assign funct_ok = (funct3 == 3'b000) || (funct3 == 3'b010) ||
                      (funct3 == 3'b110) || (funct3 == 3'b111);

    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        alu_src    = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        imm_src    = IMM_I;
        result_src = RES_ALU;
        alu_op     = ALUOP_ADD;
        case (op)
            OP_LW: begin
                reg_write  = 1'b1;
                alu_src    = 1'b1;
                result_src = RES_MEM;
            end
            OP_SW: begin
                mem_write = 1'b1;
                alu_src   = 1'b1;
                imm_src   = IMM_S;
            end
            OP_R: begin
                reg_write = funct_ok;
                alu_op    = ALUOP_FUNCT;
            end
            OP_I: begin
                reg_write = funct_ok;
                alu_src   = 1'b1;
                alu_op    = ALUOP_FUNCT;
            end
            OP_BEQ: begin
                branch  = (funct3 == 3'b000);
                imm_src = IMM_B;
                alu_op  = ALUOP_SUB;
            end
`ifdef TOP_JAL_EN
            OP_JAL: begin
                reg_write  = 1'b1;
                jump       = 1'b1;
                imm_src    = IMM_J;
                result_src = RES_PC4;
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // funct7[5] selects sub only for R-type; in addi it is an immediate bit.
                    3'b000:  alu_control = (op == OP_R && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/top_alu.sv
// top_alu: 32-bit combinational ALU.
//   in : a, b, ctrl (alu_ctrl_e)
//   out: ALUResult, Zero (ALUResult == 0)
module top_alu
    import top_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  alu_ctrl_e   ctrl,
    output logic [31:0] ALUResult,
    output logic        Zero
);

    always_comb begin
        ALUResult = '0;
        case (ctrl)
            ALU_ADD: ALUResult = a + b;
            ALU_SUB: ALUResult = a - b;
            ALU_AND: ALUResult = a & b;
            ALU_OR:  ALUResult = a | b;
            ALU_SLT: ALUResult = {31'b0, $signed(a) < $signed(b)};
            default: ALUResult = '0;
        endcase
    end

    assign Zero = (ALUResult == 32'd0);

endmodule

// File: rtl/top_dmem.sv
// top_dmem: data RAM, combinational read, write on rising CLK.
//   in : CLK, we, addr (byte address, low two bits ignored), wd
//   out: rd
// The word index wraps modulo WORDS.
module top_dmem #(
    parameter int unsigned WORDS = 64
) (
    input  logic        CLK,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    output logic [31:0] rd
);

    localparam int unsigned AW = $clog2(WORDS);

    logic [31:0] ram [0:WORDS-1];
    logic [31:0] word_idx;
    logic        unused_bits;

    assign word_idx    = {2'b00, addr[31:2]} % WORDS;
    assign rd          = ram[word_idx[AW-1:0]];
    assign unused_bits = ^{addr[1:0], word_idx[31:AW]};

    always_ff @(posedge CLK) begin
        if (we) begin
            ram[word_idx[AW-1:0]] <= wd;
        end
    end

endmodule

// File: rtl/top_imem.sv
// top_imem: instruction ROM, combinational word read.
//   in : addr (byte address, low two bits ignored)
//   out: rd
// The array rom is loaded externally through its hierarchical name; the
// word index wraps modulo WORDS.
module top_imem #(
    parameter int unsigned WORDS = 64
) (
    input  logic [31:0] addr,
    output logic [31:0] rd
);

    localparam int unsigned AW = $clog2(WORDS);

    logic [31:0] rom [0:WORDS-1];
    logic [31:0] word_idx;
    logic        unused_bits;

    assign word_idx    = {2'b00, addr[31:2]} % WORDS;
    assign rd          = rom[word_idx[AW-1:0]];
    assign unused_bits = ^{addr[1:0], word_idx[31:AW]};

endmodule

// File: rtl/top_regfile.sv
// top_regfile: 32x32 register file, two combinational read ports and one
// write port clocked on the rising edge.
//   in : CLK, we, a1/a2 (read addresses), a3 (write address), wd
//   out: rd1, rd2
// x0 reads as zero and ignores writes.
module top_regfile (
    input  logic        CLK,
    input  logic        we,
    input  logic [4:0]  a1,
    input  logic [4:0]  a2,
    input  logic [4:0]  a3,
    input  logic [31:0] wd,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);

    logic [31:0] rf [0:31];

    // NOTE: storage arrays carry no reset; only the write enable is qualified,
    // which keeps them mappable to RAM and leaves contents intact across reset.
    always_ff @(posedge CLK) begin
        // Keep the x0 entry itself at zero so it is also zero when inspected.
        rf[0] <= '0;
        if (we && a3 != 5'd0) begin
            rf[a3] <= wd;
        end
    end

    assign rd1 = (a1 == 5'd0) ? 32'd0 : rf[a1];
    assign rd2 = (a2 == 5'd0) ? 32'd0 : rf[a2];

endmodule

// File: rtl/top.sv
// top: RV32I single-cycle core (lw, sw, add, sub, and, or, slt, addi,
// andi, ori, slti, beq), one instruction per CLK.
//   in : CLK (rising edge), RST (asynchronous, active high)
// No other ports; state is observed through PC, Instr, instr_mem.rom,
// reg_file.rf, alu_inst.ALUResult and alu_inst.Zero.
// Optional feature: define TOP_JAL_EN to add jal (rd = PC+4, PC += J-imm).
module top
    import top_pkg::*;
#(
    parameter int unsigned IMEM_WORDS = 64,
    parameter int unsigned DMEM_WORDS = 64
) (
    input logic CLK,
    input logic RST
);

    logic [31:0] PC;
    logic [31:0] Instr;
    logic [31:0] pc_plus4, pc_target, pc_next;
    logic [31:0] imm_ext, rd1, rd2, alu_b, alu_result, read_data, result;
    logic        reg_write, mem_write, alu_src, branch, jump, zero;
    logic        commit_en;
    imm_src_e    imm_src;
    result_src_e result_src;
    alu_ctrl_e   alu_control;

    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples values from before the edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) PC <= '0;
        else     PC <= pc_next;
    end

    // While reset is high no architectural write commits, which also
    // drops the writeback of an instruction interrupted by reset.
    assign commit_en = ~RST;

    top_imem #(.WORDS(IMEM_WORDS)) instr_mem (
        .addr (PC),
        .rd   (Instr)
    );

    control_unit ctrl (
        .op          (Instr[6:0]),
        .funct3      (Instr[14:12]),
        .funct7b5    (Instr[30]),
        .reg_write   (reg_write),
        .mem_write   (mem_write),
        .alu_src     (alu_src),
        .branch      (branch),
        .jump        (jump),
        .imm_src     (imm_src),
        .result_src  (result_src),
        .alu_control (alu_control)
    );

    top_regfile reg_file (
        .CLK (CLK),
        .we  (reg_write & commit_en),
        .a1  (Instr[19:15]),
        .a2  (Instr[24:20]),
        .a3  (Instr[11:7]),
        .wd  (result),
        .rd1 (rd1),
        .rd2 (rd2)
    );

    assign imm_ext = imm_extend(Instr[31:7], imm_src);
    assign alu_b   = alu_src ? imm_ext : rd2;

    top_alu alu_inst (
        .a         (rd1),
        .b         (alu_b),
        .ctrl      (alu_control),
        .ALUResult (alu_result),
        .Zero      (zero)
    );

    top_dmem #(.WORDS(DMEM_WORDS)) data_mem (
        .CLK  (CLK),
        .we   (mem_write & commit_en),
        .addr (alu_result),
        .wd   (rd2),
        .rd   (read_data)
    );

    always_comb begin
        case (result_src)
            RES_MEM: result = read_data;
            RES_PC4: result = pc_plus4;
            default: result = alu_result;
        endcase
    end

    assign pc_plus4  = PC + 32'd4;
    assign pc_target = PC + imm_ext;
    assign pc_next   = ((branch & zero) | jump) ? pc_target : pc_plus4;

endmodule

// File: tb/tb_top.sv
// tb_top: self-checking bench for the single-cycle RV32I core.
// Directed program first (arithmetic, logic, branches, memory, x0,
// asynchronous mid-program reset), then a random program compared cycle by
// cycle with an instruction-level reference model.
module tb_top;

    localparam int IM = 64;
    localparam int DM = 64;

    logic CLK;
    logic RST;

    int checks;
    int errors;

    // Reference model state (architectural view only).
    bit [31:0] m_rom [IM];
    bit [31:0] m_rf  [32];
    bit [31:0] m_dm  [DM];
    bit [31:0] m_pc;

    top #(.IMEM_WORDS(IM), .DMEM_WORDS(DM)) dut (
        .CLK (CLK),
        .RST (RST)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish within its time budget");
        $fatal(1);
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // ---------------- instruction encoders ----------------
    function automatic bit [31:0] enc_r(bit [6:0] f7, bit [4:0] rs2, bit [4:0] rs1, bit [2:0] f3, bit [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction
    function automatic bit [31:0] enc_i(bit [11:0] imm, bit [4:0] rs1, bit [2:0] f3, bit [4:0] rd, bit [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic bit [31:0] enc_s(bit [11:0] imm, bit [4:0] rs2, bit [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction
    function automatic bit [31:0] enc_b(bit [12:0] imm, bit [4:0] rs2, bit [4:0] rs1);
        return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic bit [31:0] enc_j(bit [20:0] imm, bit [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    // ---------------- reference model: one instruction ----------------
    function automatic void model_step();
        bit [31:0] ins, a, b, imm_i, imm_s, imm_b, imm_j, wval, npc;
        bit [4:0]  rd, rs1, rs2;
        bit [2:0]  f3;
        bit        wr;
        ins   = m_rom[(m_pc >> 2) % IM];
        rd    = ins[11:7];
        rs1   = ins[19:15];
        rs2   = ins[24:20];
        f3    = ins[14:12];
        a     = m_rf[rs1];
        b     = m_rf[rs2];
        imm_i = 32'($signed(ins[31:20]));
        imm_s = 32'($signed({ins[31:25], ins[11:7]}));
        imm_b = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
        imm_j = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
        npc   = m_pc + 4;
        wr    = 0;
        wval  = 0;
        case (ins[6:0])
            7'h33, 7'h13: begin
                if (ins[6:0] == 7'h13) b = imm_i;
                wr = 1;
                case (f3)
                    3'd0: wval = (ins[6:0] == 7'h33 && ins[30]) ? a - b : a + b;
                    3'd7: wval = a & b;
                    3'd6: wval = a | b;
                    3'd2: wval = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    default: wr = 0;
                endcase
            end
            7'h03: begin
                wr   = 1;
                wval = m_dm[((a + imm_i) >> 2) % DM];
            end
            7'h23: m_dm[((a + imm_s) >> 2) % DM] = b;
            7'h63: if (f3 == 3'd0 && a == b) npc = m_pc + imm_b;
`ifdef TOP_JAL_EN
            7'h6F: begin
                wr   = 1;
                wval = m_pc + 4;
                npc  = m_pc + imm_j;
            end
`endif
            default: ;
        endcase
        if (wr && rd != 0) m_rf[rd] = wval;
        m_pc = npc;
    endfunction

    // ---------------- directed program ----------------
    task automatic load_directed();
        bit [31:0] prog [0:14];
        prog[0]  = 32'h00500113; // addi x2,x0,5
        prog[1]  = 32'h00C00193; // addi x3,x0,12
        prog[2]  = 32'hFF718393; // addi x7,x3,-9
        prog[3]  = 32'h0023E233; // or   x4,x7,x2
        prog[4]  = 32'h0041F2B3; // and  x5,x3,x4
        prog[5]  = 32'h004282B3; // add  x5,x5,x4
        prog[6]  = 32'h02728863; // beq  x5,x7,+48
        prog[7]  = 32'h0041A233; // slt  x4,x3,x4
        prog[8]  = 32'h00020463; // beq  x4,x0,+8
        prog[9]  = 32'h06300113; // addi x2,x0,99 (skipped)
        prog[10] = 32'h00202023; // sw   x2,0(x0)
        prog[11] = 32'h00002303; // lw   x6,0(x0)
        prog[12] = 32'h00100013; // addi x0,x0,1
        prog[13] = 32'h00900113; // addi x2,x0,9
        prog[14] = 32'h00100193; // addi x3,x0,1 (interrupted by reset)
        for (int i = 0; i < IM; i++) dut.instr_mem.rom[i] = (i < 15) ? prog[i] : 32'h0;
    endtask

    task automatic test_reset();
        RST = 1;
        #1;
        chk32("reset_pc_async", dut.PC, 32'h0);
        load_directed();
        step();
        chk32("reset_pc_held", dut.PC, 32'h0);
        @(negedge CLK);
        RST = 0;
    endtask

    task automatic test_addi();
        step();
        step();
        chk32("alu_result_cycle3", dut.alu_inst.ALUResult, 32'd3);
        step();
        chk32("x2_addi", dut.reg_file.rf[2], 32'd5);
        chk32("x3_addi", dut.reg_file.rf[3], 32'd12);
        chk32("x7_addi_neg", dut.reg_file.rf[7], 32'd3);
        chk32("pc_after_addi", dut.PC, 32'h0C);
    endtask

    task automatic test_logic();
        bit [31:0] exp_reg [3];
        int        exp_idx [3];
        exp_reg = '{32'd7, 32'd4, 32'd11};
        exp_idx = '{4, 5, 5};
        for (int k = 0; k < 3; k++) begin
            chk32("zero_low_rtype", {31'b0, dut.alu_inst.Zero}, 32'd0);
            step();
            chk32("rtype_result", dut.reg_file.rf[exp_idx[k]], exp_reg[k]);
        end
    endtask

    task automatic test_branch();
        chk32("pc_at_beq_nt", dut.PC, 32'h18);
        step();
        chk32("beq_not_taken", dut.PC, 32'h1C);
        chk32("slt_alu_result", dut.alu_inst.ALUResult, 32'd0);
        chk32("slt_zero", {31'b0, dut.alu_inst.Zero}, 32'd1);
        step();
        chk32("slt_x4", dut.reg_file.rf[4], 32'd0);
        chk32("pc_at_beq_t", dut.PC, 32'h20);
        step();
        chk32("beq_taken", dut.PC, 32'h28);
    endtask

    task automatic test_mem_x0();
        step();
        chk32("sw_word0", dut.data_mem.ram[0], 32'd5);
        step();
        chk32("lw_x6", dut.reg_file.rf[6], 32'd5);
        step();
        chk32("x0_stays_zero", dut.reg_file.rf[0], 32'd0);
        chk32("pc_after_x0", dut.PC, 32'h34);
        step();
        chk32("x2_reload", dut.reg_file.rf[2], 32'd9);
        chk32("pc_before_rst", dut.PC, 32'h38);
    endtask

    task automatic test_mid_reset();
        bit [31:0] exp [8];
        exp = '{32'd0, 32'd0, 32'd9, 32'd12, 32'd0, 32'd11, 32'd5, 32'd3};
        #2;
        RST = 1;
        #1;
        chk32("mid_reset_pc_async", dut.PC, 32'h0);
        step();
        chk32("mid_reset_pc_held", dut.PC, 32'h0);
        for (int r = 2; r < 8; r++) chk32("mid_reset_rf", dut.reg_file.rf[r], exp[r]);
        @(negedge CLK);
        RST = 0;
        step();
        chk32("first_after_reset_pc", dut.PC, 32'h4);
        chk32("first_after_reset_x2", dut.reg_file.rf[2], 32'd5);
    endtask

    // ---------------- random program ----------------
    function automatic bit [31:0] rand_instr();
        bit [4:0]  rd, rs1, rs2;
        bit [11:0] imm;
        int        off;
        int        kind;
        rd   = 5'($urandom_range(0, 7));
        rs1  = 5'($urandom_range(0, 7));
        rs2  = 5'($urandom_range(0, 7));
        imm  = ($urandom_range(0, 1) == 0) ? 12'($urandom) : 12'(int'($urandom_range(0, 8)) - 4);
        kind = int'($urandom_range(0, 13));
        case (kind)
            0:  return enc_r(7'h00, rs2, rs1, 3'd0, rd);
            1:  return enc_r(7'h20, rs2, rs1, 3'd0, rd);
            2:  return enc_r(7'h00, rs2, rs1, 3'd7, rd);
            3:  return enc_r(7'h00, rs2, rs1, 3'd6, rd);
            4:  return enc_r(7'h00, rs2, rs1, 3'd2, rd);
            5:  return enc_i(imm, rs1, 3'd0, rd, 7'h13);
            6:  return enc_i(imm, rs1, 3'd7, rd, 7'h13);
            7:  return enc_i(imm, rs1, 3'd6, rd, 7'h13);
            8:  return enc_i(imm, rs1, 3'd2, rd, 7'h13);
            9, 10: begin
                // Words 0..3, optionally via a negative offset that wraps and
                // with unaligned low bits.
                off = int'($urandom_range(0, 3)) * 4 + int'($urandom_range(0, 3));
                if ($urandom_range(0, 1) == 1) off = off - 256;
                if (kind == 9) return enc_i(12'(off), 5'd0, 3'd2, rd, 7'h03);
                return enc_s(12'(off), rs2, 5'd0);
            end
            11: begin
                off = (int'($urandom_range(0, 8)) - 4) * 4;
                if (off == 0) off = 8;
                return enc_b(13'(off), rs2, rs1);
            end
            12: begin
                off = (int'($urandom_range(0, 8)) - 4) * 4;
                if (off == 0) off = 12;
                return enc_j(21'(off), rd);
            end
            default: return {imm, rs1, 3'd0, rd, 7'b0110111};
        endcase
    endfunction

    task automatic test_random();
        bit ok;
        @(negedge CLK);
        RST = 1;
        // Preamble: seed x1..x7 and data words 0..3 so the model state is known.
        for (int r = 1; r < 8; r++) begin
            bit [11:0] v;
            v = ($urandom_range(0, 2) == 0) ? 12'($urandom) : 12'(int'($urandom_range(0, 6)) - 3);
            m_rom[r - 1] = enc_i(v, 5'd0, 3'd0, 5'(r), 7'h13);
        end
        for (int w = 0; w < 4; w++) m_rom[7 + w] = enc_s(12'(w * 4), 5'(w + 1), 5'd0);
        for (int i = 11; i < IM; i++) m_rom[i] = rand_instr();
        for (int i = 0; i < IM; i++) dut.instr_mem.rom[i] = m_rom[i];
        for (int r = 0; r < 32; r++) m_rf[r] = 0;
        m_pc = 0;
        @(negedge CLK);
        chk32("rand_reset_pc", dut.PC, 32'h0);
        RST = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            step();
            model_step();
            chk32("rand_pc", dut.PC, m_pc);
            if (cyc >= 11) begin
                ok = 1;
                checks++;
                for (int r = 0; r < 8; r++) begin
                    if (ok && dut.reg_file.rf[r] !== m_rf[r]) begin
                        ok = 0;
                        errors++;
                        $display("FAIL rand_rf cycle %0d x%0d: got %h expected %h",
                                 cyc, r, dut.reg_file.rf[r], m_rf[r]);
                    end
                end
            end
        end
        for (int w = 0; w < 4; w++) chk32("rand_dmem", dut.data_mem.ram[w], m_dm[w]);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        CLK    = 0;
        RST    = 1;
        test_reset();
        test_addi();
        test_logic();
        test_branch();
        test_mem_x0();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 Parameter IMEM_WORDS, default 64, instruction ROM depth in 32-bit words.
REQ-002 Parameter DMEM_WORDS, default 64, data RAM depth in 32-bit words.
REQ-003 Port CLK  input  1  single system clock; all state updates on rising edge.
REQ-004 Port RST  input  1  asynchronous, active-high reset.
REQ-005 No other ports; observability is via the hierarchical names in REQ-030.

Function
REQ-006 The block SHALL be an RV32I single-cycle core: fetch, decode, execute, memory access and writeback of one instruction per CLK cycle.
REQ-007 Supported instructions: lw, sw, add, sub, and, or, slt (R-type); addi, andi, ori, slti (I-type); beq.
REQ-008 PC SHALL be 32 bits and word-aligned; instruction fetch reads rom[PC[31:2]] combinationally.
REQ-009 On each rising CLK, PC SHALL load PC+4, or PC+SignExt(B-imm) when beq is taken.
REQ-010 beq SHALL be taken when ALU SUB of rs1 and rs2 yields Zero=1.
REQ-011 The ALU SHALL be 32-bit with add, sub, and, or, slt (signed); Zero = (ALUResult == 0), combinational.
REQ-012 ALU operand B SHALL be rs2 for R-type and beq, and the sign-extended 12-bit immediate for I-type, lw and sw.
REQ-013 Immediates SHALL be sign-extended from bit 31; I, S and B formats are supported, and the B-immediate LSB is 0.
REQ-014 Register file: 32x32, two combinational read ports, one write port written on rising CLK when RegWrite=1.
REQ-015 x0 SHALL always read 0; writes to x0 are discarded.
REQ-016 Writeback data (Result) SHALL be the data RAM read for lw and ALUResult otherwise.
REQ-017 sw SHALL write rs2 to dmem[ALUResult[31:2]] on rising CLK; lw reads combinationally.
REQ-018 Memory addresses SHALL wrap modulo the array depth; unaligned low bits are ignored.
REQ-019 Unsupported opcodes SHALL execute as no-ops (no register or memory write, PC+4).

Reset
REQ-020 While RST=1, PC SHALL be 0x00000000 immediately and asynchronously, and register and memory writes are suppressed.
REQ-021 The register file, data RAM and ROM SHALL NOT be cleared by reset.
REQ-022 After RST deasserts, the first rising CLK SHALL execute the instruction at 0x00000000.
REQ-023 Reset asserted mid-program SHALL abort the current instruction without committing its writeback.

Configuration
REQ-024 Macro TOP_JAL_EN: when defined, jal SHALL be supported: rd = PC+4 and PC = PC+SignExt(J-imm).
REQ-025 Without TOP_JAL_EN, opcode 1101111 SHALL behave as a no-op per REQ-019.

Structure
REQ-026 Package top_pkg SHALL hold the opcode constants, ALUControl encodings and the ALU-op/ImmSrc/ResultSrc typedefs.
REQ-027 A combinational control decoder SHALL be a separate sub-module named control_unit.
REQ-028 The ALU, register file and instruction ROM SHALL be sub-modules, instanced as alu_inst, reg_file and instr_mem respectively.
REQ-029 The data RAM SHALL be an array inside the data memory block.
REQ-030 Required hierarchical names: top.PC, top.Instr, top.instr_mem.rom (array loadable via $readmemh), top.reg_file.rf[0:31], top.alu_inst.ALUResult, top.alu_inst.Zero.

Verification
REQ-031 Load 00500113, 00C00193, FF718393, then release reset and clock 3 cycles -> x2=5, x3=12, x7=3; ALUResult=3 on the third cycle.
REQ-032 Execute 0023E233, 0041F2B3, 004282B3 next -> x4=7, x5=4, then x5=11; Zero=0 throughout.
REQ-033 Execute 02728863 (beq x5,x7) at PC 0x18 -> not taken, next PC=0x1C; then 0041A233 (slt) -> x4=0 and Zero=1.
REQ-034 Execute 00020463 (beq x4,x0,+8) at PC 0x20 -> taken, next PC=0x28.
REQ-035 Execute sw x2,0(x0) then lw x6,0(x0) -> x6=5; addi x0,x0,1 -> x0 remains 0.
REQ-036 Assert RST mid-program -> PC=0 immediately, without waiting for a CLK edge; the register file is unchanged.
